// File: rtl/multi_counter.sv
// multi_counter: per-channel prescaled event counters with wrap/saturate modes
//   clk_i        clock, all state updates on rising edge
//   reset_i      synchronous active-high reset (clears everything, all channels wrap, divide-by-1)
//   en_i/slt_i   count enable for channel slt_i
//   cfg_we_i     config strobe: loads cfg_div_i/cfg_sat_i into channel cfg_ch_i, zeroes its prescaler
//   clr_i        clears count, prescaler and overflow of channel rd_ch_i
//   rd_ch_i      readout select; rd_count_o is zero for out-of-range channels
//   ovf_o        sticky per-channel overflow flags
//   tick_o       one-cycle pulse in the cycle after any count event
module multi_counter #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int DIV_W    = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic [CH_W-1:0]     slt_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    input  logic                cfg_sat_i,
    input  logic                clr_i,
    input  logic [CH_W-1:0]     rd_ch_i,
    output logic [WIDTH-1:0]    rd_count_o,
    output logic [CHANNELS-1:0] ovf_o,
    output logic                tick_o
);
    logic [CHANNELS-1:0][WIDTH-1:0] c_q, c_d;
    logic [CHANNELS-1:0][DIV_W-1:0] p_q, p_d, d_q, d_d;
    logic [CHANNELS-1:0]            s_q, s_d, o_q, o_d;
    logic [CHANNELS-1:0]            hit, cfg, clr, ev;
    logic                           tick_q, tick_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_sel
        assign hit[c] = en_i && slt_i == CH_W'(c);
        assign cfg[c] = cfg_we_i && cfg_ch_i == CH_W'(c);
        assign clr[c] = clr_i && rd_ch_i == CH_W'(c);
        // a config write suppresses prescaler advance, a clear suppresses the count itself
        assign ev[c]  = hit[c] && !cfg[c] && !clr[c] && p_q[c] == d_q[c];
    end

    always_comb begin
        c_d    = c_q;
        p_d    = p_q;
        d_d    = d_q;
        s_d    = s_q;
        o_d    = o_q;
        tick_d = |ev;
        for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c] && !cfg[c])
                p_d[c] = (p_q[c] == d_q[c]) ? '0 : p_q[c] + 1'b1;
            if (ev[c]) begin
                o_d[c] = o_q[c] | (&c_q[c]);
                c_d[c] = !(&c_q[c]) ? c_q[c] + 1'b1 : (s_q[c] ? c_q[c] : '0);
            end
            if (cfg[c]) begin
                d_d[c] = cfg_div_i;
                s_d[c] = cfg_sat_i;
                p_d[c] = '0;
            end
            if (clr[c]) begin
                c_d[c] = '0;
                p_d[c] = '0;
                o_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            c_q    <= '0;
            p_q    <= '0;
            d_q    <= '0;
            s_q    <= '0;
            o_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            p_q    <= p_d;
            d_q    <= d_d;
            s_q    <= s_d;
            o_q    <= o_d;
            tick_q <= tick_d;
        end
    end

    assign rd_count_o = (32'(rd_ch_i) < CHANNELS) ? c_q[rd_ch_i] : '0;
    assign ovf_o      = o_q;
    assign tick_o     = tick_q;
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: scoreboard bench for multi_counter (WIDTH=4 to reach overflow quickly)
module tb_multi_counter;
    localparam int W = 4, N = 4, CW = 2, DW = 8;

    logic          clk = 1'b0, reset_i = 1'b0, en_i = 1'b0, cfg_we_i = 1'b0, cfg_sat_i = 1'b0, clr_i = 1'b0;
    logic [CW-1:0] slt_i = '0, cfg_ch_i = '0, rd_ch_i = '0;
    logic [DW-1:0] cfg_div_i = '0;
    logic [W-1:0]  rd_count_o;
    logic [N-1:0]  ovf_o;
    logic          tick_o;

    always #5 clk = ~clk;

    multi_counter #(.WIDTH(W), .CHANNELS(N), .CH_W(CW), .DIV_W(DW)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .slt_i(slt_i),
        .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i), .cfg_sat_i(cfg_sat_i),
        .clr_i(clr_i), .rd_ch_i(rd_ch_i), .rd_count_o(rd_count_o), .ovf_o(ovf_o), .tick_o(tick_o)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [N-1:0] ovf;
        logic         tick;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    logic [W-1:0]  mc[N];
    logic [DW-1:0] mp[N], md[N];
    logic          ms[N], mo[N];
    logic          mt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cycle(input logic rst, input logic en, input int slt, input logic we, input int cch,
                         input int div, input logic sat, input logic clr, input int rch);
        exp_t e;
        logic ev;
        reset_i = rst; en_i = en; slt_i = CW'(slt); cfg_we_i = we; cfg_ch_i = CW'(cch);
        cfg_div_i = DW'(div); cfg_sat_i = sat; clr_i = clr; rd_ch_i = CW'(rch);
        mt = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                mc[c] = '0; mp[c] = '0; md[c] = '0; ms[c] = 1'b0; mo[c] = 1'b0;
            end else begin
                ev = 1'b0;
                if (en && slt == c && !(we && cch == c)) begin
                    if (mp[c] == md[c]) begin
                        mp[c] = '0;
                        ev = !(clr && rch == c);
                    end else mp[c] = mp[c] + 1;
                end
                if (ev) begin
                    mt = 1'b1;
                    if (mc[c] == {W{1'b1}}) begin
                        mo[c] = 1'b1;
                        if (!ms[c]) mc[c] = '0;
                    end else mc[c] = mc[c] + 1;
                end
                if (we && cch == c) begin md[c] = DW'(div); ms[c] = sat; mp[c] = '0; end
                if (clr && rch == c) begin mc[c] = '0; mp[c] = '0; mo[c] = 1'b0; end
            end
        end
        e.cnt = (rch < N) ? mc[rch] : '0;
        for (int c = 0; c < N; c++) e.ovf[c] = mo[c];
        e.tick = mt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("rd_count", 64'(rd_count_o), 64'(e.cnt));
        check("ovf", 64'(ovf_o), 64'(e.ovf));
        check("tick", 64'(tick_o), 64'(e.tick));
    endtask

    task automatic run_en(input int n, input int ch);
        for (int i = 0; i < n; i++) cycle(0, 1, ch, 0, 0, 0, 0, 0, ch);
    endtask

    task automatic idle(input int rch);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, rch);
    endtask

    initial begin
        cycle(1, 1, 0, 1, 0, 5, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_count", 64'(rd_count_o), 0);
        check("reset_tick", 64'(tick_o), 0);
        // five enabled cycles on ch0, divide-by-1
        run_en(5, 0);
        check("ch0_five", 64'(rd_count_o), 5);
        idle(0);
        check("tick_drop", 64'(tick_o), 0);
        for (int c = 1; c < N; c++) idle(c);
        // ch1 divide-by-4
        cycle(0, 0, 0, 1, 1, 3, 0, 0, 1);
        run_en(8, 1);
        check("ch1_div4", 64'(rd_count_o), 2);
        // ch2 wrap, ch3 saturate
        run_en(16, 2);
        check("ch2_wrap", 64'(rd_count_o), 0);
        check("ch2_ovf", 64'(ovf_o), 4'b0100);
        cycle(0, 0, 0, 1, 3, 0, 1, 0, 3);
        run_en(20, 3);
        check("ch3_sat", 64'(rd_count_o), 15);
        check("ch3_ovf", 64'(ovf_o[3]), 1);
        // clear beats count on ch0
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_en(7, 0);
        check("ch0_seven", 64'(rd_count_o), 7);
        cycle(0, 1, 0, 0, 0, 0, 0, 1, 0);
        check("clr_count", 64'(rd_count_o), 0);
        check("clr_tick", 64'(tick_o), 0);
        // config and clear together on ch2
        cycle(0, 1, 2, 1, 2, 1, 1, 1, 2);
        check("clr_cfg_ovf", 64'(ovf_o[2]), 0);
        // reset mid-prescale discards divisor and progress
        cycle(0, 0, 0, 1, 1, 3, 0, 0, 1);
        run_en(2, 1);
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 1);
        check("rst_ovf", 64'(ovf_o), 0);
        check("rst_tick", 64'(tick_o), 0);
        run_en(1, 1);
        check("post_rst_ch1", 64'(rd_count_o), 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(N - 1),
                  $urandom_range(9) == 0, $urandom_range(N - 1), $urandom_range(3),
                  $urandom_range(1), $urandom_range(19) == 0, $urandom_range(N - 1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
